// File: rtl/shift_pkg.sv
// shift_pkg: shared types and constants for the multi-pass shift sequencer
package shift_pkg;

    localparam int DATA_W   = 64;
    localparam int STEP_MAX = 31;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic {
        OP_ASL = 1'b0,
        OP_LSL = 1'b1
    } op_t;

endpackage

// File: rtl/shift_pass_stage.sv
// shift_pass_stage: one 0..31-bit left-shift pass with overflow detection
module shift_pass_stage
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] cur,
    input  logic [4:0]        n,
    input  op_t               op,
    input  logic              sign,
    output logic [DATA_W-1:0] nxt,
    output logic              ovf
);

    logic [DATA_W-1:0] v;
    logic              fill;

    // 16/8/4/2/1 ladder; ASL parks its 63 magnitude bits at the top so both ops test the same bits leaving the word
    always_comb begin
        fill = (op == OP_ASL) ? sign : 1'b0;
        v    = (op == OP_ASL) ? {cur[DATA_W-2:0], 1'b0} : cur;
        ovf  = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (n[i]) begin
                ovf = ovf | (|((v ^ {DATA_W{fill}}) & ~({DATA_W{1'b1}} >> (1 << i))));
                v   = v << (1 << i);
            end
        end
        nxt = (op == OP_ASL) ? {sign, v[DATA_W-1:1]} : v;
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences 0..63-bit left shifts through a 0..31-bit pass stage
module shift_sequencer
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [5:0]        in_amt,
    input  logic              in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] cur, pass_data;
    logic [5:0]        rem, rem_nxt;
    logic [4:0]        n;
    op_t               op;
    logic              sign, ovf, pass_ovf, ovf_nxt;

    shift_pass_stage u_pass (
        .cur  (cur),
        .n    (n),
        .op   (op),
        .sign (sign),
        .nxt  (pass_data),
        .ovf  (pass_ovf)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Step size, remaining count and next state; flush overrides any handshake
    always_comb begin
        n         = (rem > 6'(STEP_MAX)) ? 5'(STEP_MAX) : rem[4:0];
        rem_nxt   = rem - {1'b0, n};
        ovf_nxt   = ovf | pass_ovf;
        state_nxt = state;
        if (flush && state != IDLE)
            state_nxt = IDLE;
        else if (state == IDLE && in_valid)
            state_nxt = SHIFT;
        else if (state == SHIFT && rem_nxt == 6'd0)
            state_nxt = DONE;
        else if (state == DONE && out_ready)
            state_nxt = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Working operand and result registers; the result is published only when the last pass completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= '0;
            rem      <= '0;
            op       <= OP_ASL;
            sign     <= 1'b0;
            ovf      <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            cur  <= in_data;
            rem  <= in_amt;
            op   <= op_t'(in_op);
            sign <= in_data[DATA_W-1];
            ovf  <= 1'b0;
        end else if (state == SHIFT && !flush) begin
            cur <= pass_data;
            rem <= rem_nxt;
            ovf <= ovf_nxt;
            if (rem_nxt == 6'd0) begin
                out_data <= pass_data;
                out_ovf  <= ovf_nxt;
            end
        end
    end

endmodule
